axi_probe_target: RTL and testbench

AXI-lite-subset responder holding a small byte-strobed register file, used as the far end of the UART probe's AXI master channels. It accepts single-beat reads and writes, answers with OKAY or SLVERR, and supports bring-up and regression of the probe without a full SoC interconnect. Independent read and write state machines share one storage array.

---
 rtl/axi_probe_pkg.sv | 16 +
 rtl/axi_probe_target_if.sv | 32 +++
 rtl/axi_target_regfile.sv | 38 +++
 rtl/axi_probe_target.sv | 196 +++++++++++++++++++
 tb/tb_axi_probe_target.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_probe_pkg.sv
// Shared response codes and FSM state types for the AXI-lite probe target.
// AXI_TARGET_WAIT_EN adds the read wait state used for programmable read latency.
package axi_probe_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIdle, WAheld, WDheld, WResp} wr_state_e;

`ifdef AXI_TARGET_WAIT_EN
  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;
`else
  typedef enum logic {RIdle, RResp} rd_state_e;
`endif

endpackage

// File: rtl/axi_probe_target_if.sv
// AXI-lite subset bus between the probe master and the register-file target.
interface axi_probe_target_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_target_regfile.sv
// NumWords x 32 storage: one byte-strobed write port, one registered read port,
// synchronous clear of every word and of the read register.
module axi_target_regfile #(
  parameter int unsigned NumWords = 16,
  parameter int unsigned AddrW    = $clog2(NumWords)
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [NumWords];
  logic [31:0] rdata_q;

  // Read samples the pre-write contents when both ports hit the same word.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < int'(NumWords); i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_probe_target.sv
// AXI-lite subset responder: address decode, independent read/write FSMs over a shared regfile.
// Define AXI_TARGET_WAIT_EN to stretch read latency to RD_LATENCY cycles.
module axi_probe_target
  import axi_probe_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_WORDS  = 16,
  parameter int unsigned RD_LATENCY = 4
) (
  input  logic               clk,
  input  logic               s_areset,
  axi_probe_target_if.slave  s_axi
);

  localparam int unsigned AddrW = $clog2(NUM_WORDS);
  localparam logic [29:0] BaseW = BASE_ADDR[31:2];

  if ((BASE_ADDR[1:0] != 2'b00) || (NUM_WORDS < 2) || (NUM_WORDS > 256) ||
      ((NUM_WORDS & (NUM_WORDS - 1)) != 0) || (RD_LATENCY < 1) || (RD_LATENCY > 15))
  begin : g_param_err
    $error("axi_probe_target: illegal parameter value");
  end

  // Sub-word address bits and transfer sizes carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi.arsize, s_axi.awsize, s_axi.araddr[1:0], s_axi.awaddr[1:0]};

  // ---------------- write path ----------------
  wr_state_e   w_state_q, w_state_d;
  logic [29:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs, commit, cm_hit;
  logic [29:0] cm_addr, cm_off;
  logic [31:0] cm_data;
  logic [3:0]  cm_strb;

  assign s_axi.awready = !s_areset && ((w_state_q == WIdle) || (w_state_q == WDheld));
  assign s_axi.wready  = !s_areset && ((w_state_q == WIdle) || (w_state_q == WAheld));
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    commit    = 1'b0;
    cm_addr   = awaddr_q;
    cm_data   = wdata_q;
    cm_strb   = wstrb_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          cm_addr   = s_axi.awaddr[31:2];
          cm_data   = s_axi.wdata;
          cm_strb   = s_axi.wstrb;
          w_state_d = WResp;
        end else if (aw_hs) begin
          awaddr_d  = s_axi.awaddr[31:2];
          w_state_d = WAheld;
        end else if (w_hs) begin
          wdata_d   = s_axi.wdata;
          wstrb_d   = s_axi.wstrb;
          w_state_d = WDheld;
        end
      end
      WAheld: begin
        if (w_hs) begin
          commit    = 1'b1;
          cm_data   = s_axi.wdata;
          cm_strb   = s_axi.wstrb;
          w_state_d = WResp;
        end
      end
      WDheld: begin
        if (aw_hs) begin
          commit    = 1'b1;
          cm_addr   = s_axi.awaddr[31:2];
          w_state_d = WResp;
        end
      end
      WResp:   if (s_axi.bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  assign cm_off  = cm_addr - BaseW;
  assign cm_hit  = (cm_addr >= BaseW) && ({2'b00, cm_off} < NUM_WORDS);
  assign bresp_d = commit ? (cm_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : bresp_q;

  always_ff @(posedge clk) begin
    if (s_areset) begin
      w_state_q <= WIdle;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_axi.bvalid = !s_areset && (w_state_q == WResp);
  assign s_axi.bresp  = s_areset ? 2'b00 : bresp_q;

  // ---------------- read path ----------------
  rd_state_e   r_state_q, r_state_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs, ar_hit;
  logic [29:0] ar_off;
  logic [31:0] rf_rdata;

  assign s_axi.arready = !s_areset && (r_state_q == RIdle);
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign ar_off  = s_axi.araddr[31:2] - BaseW;
  assign ar_hit  = (s_axi.araddr[31:2] >= BaseW) && ({2'b00, ar_off} < NUM_WORDS);
  assign rresp_d = ar_hs ? (ar_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR) : rresp_q;

`ifdef AXI_TARGET_WAIT_EN
  logic [3:0] rcnt_q, rcnt_d;
`endif

  always_comb begin
    r_state_d = r_state_q;
`ifdef AXI_TARGET_WAIT_EN
    rcnt_d    = rcnt_q;
`endif
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
`ifdef AXI_TARGET_WAIT_EN
          if (RD_LATENCY == 1) begin
            r_state_d = RResp;
          end else begin
            r_state_d = RWait;
            rcnt_d    = 4'(RD_LATENCY - 1);
          end
`else
          r_state_d = RResp;
`endif
        end
      end
`ifdef AXI_TARGET_WAIT_EN
      RWait: begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) r_state_d = RResp;
      end
`endif
      RResp:   if (s_axi.rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_areset) begin
      r_state_q <= RIdle;
      rresp_q   <= AXI_RESP_OKAY;
`ifdef AXI_TARGET_WAIT_EN
      rcnt_q    <= '0;
`endif
    end else begin
      r_state_q <= r_state_d;
      rresp_q   <= rresp_d;
`ifdef AXI_TARGET_WAIT_EN
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  assign s_axi.rvalid = !s_areset && (r_state_q == RResp);
  assign s_axi.rresp  = s_areset ? 2'b00 : rresp_q;
  assign s_axi.rdata  = (!s_areset && (rresp_q == AXI_RESP_OKAY)) ? rf_rdata : 32'h0;

  axi_target_regfile #(
    .NumWords (NUM_WORDS),
    .AddrW    (AddrW)
  ) u_regfile (
    .clk_i   (clk),
    .clr_i   (s_areset),
    .we_i    (commit && cm_hit),
    .waddr_i (cm_off[AddrW-1:0]),
    .wdata_i (cm_data),
    .wstrb_i (cm_strb),
    .re_i    (ar_hs),
    .raddr_i (ar_off[AddrW-1:0]),
    .rdata_o (rf_rdata)
  );

endmodule

// File: tb/tb_axi_probe_target.sv
// Randomized and directed bench for axi_probe_target against a word-array reference model.
module tb_axi_probe_target;

  localparam logic [31:0] Base   = 32'h0000_0100;
  localparam int unsigned NWords = 16;
`ifdef AXI_TARGET_WAIT_EN
  localparam int ExpLat = 4;
`else
  localparam int ExpLat = 1;
`endif

  logic clk = 1'b0;
  logic s_areset;
  always #5 clk = ~clk;

  axi_probe_target_if bus ();

  axi_probe_target #(
    .BASE_ADDR  (Base),
    .NUM_WORDS  (NWords),
    .RD_LATENCY (4)
  ) u_dut (
    .clk      (clk),
    .s_areset (s_areset),
    .s_axi    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_mem [NWords];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] addr, output int unsigned idx);
    idx = 0;
    if (addr < Base) return 1'b0;
    idx = (addr - Base) / 4;
    return idx < NWords;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int unsigned idx;
    if (!model_hit(addr, idx)) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int unsigned idx;
    if (model_hit(addr, idx)) begin
      d = model_mem[idx];
      r = 2'b00;
    end else begin
      d = 32'h0;
      r = 2'b10;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NWords); i++) model_mem[i] = 32'h0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bp);
    bit aw_done = 0;
    bit w_done = 0;
    logic [1:0] exp_r;
    logic [1:0] first_r;
    @(posedge clk); #1;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("aw_w_accept", 32'(aw_done && w_done), 32'd1);
    exp_r = model_write(addr, data, strb);
    @(negedge clk);
    check("b_lat", 32'(bus.bvalid), 32'd1);
    check("bresp", 32'(bus.bresp), 32'(exp_r));
    first_r = bus.bresp;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("b_hold_valid", 32'(bus.bvalid), 32'd1);
      check("b_hold_resp", 32'(bus.bresp), 32'(first_r));
      check("b_hold_rdy", 32'({bus.awready, bus.wready}), 32'd0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    check("b_drop", 32'(bus.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int bp, output logic [31:0] data);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int lat = 0;
    @(posedge clk); #1;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    @(negedge clk);
    check("arready", 32'(bus.arready), 32'd1);
    model_read(addr, exp_d, exp_r);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.rvalid) lat = i;
    end
    check("r_lat", 32'(lat), 32'(ExpLat));
    data = bus.rdata;
    check("rdata", bus.rdata, exp_d);
    check("rresp", 32'(bus.rresp), 32'(exp_r));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("r_hold_valid", 32'(bus.rvalid), 32'd1);
      check("r_hold_data", bus.rdata, exp_d);
      check("r_hold_rdy", 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    @(negedge clk);
    check("r_drop", 32'(bus.rvalid), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 9);
    if (sel <= 6) return Base + 4 * $urandom_range(0, NWords - 1) + $urandom_range(0, 3);
    if (sel == 7) return Base + 4 * NWords + 4 * $urandom_range(0, 15);
    if (sel == 8) return Base - 4 * $urandom_range(1, 16);
    return $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] old_d;
    logic [1:0]  old_r;
    int r_lat, b_lat, stray;
    logic [31:0] r_seen;
    logic [1:0]  b_seen;

    s_areset    = 1'b1;
    bus.araddr  = '0; bus.arsize = 3'd2; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr  = '0; bus.awsize = 3'd2; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb  = '0;   bus.wvalid  = 1'b0; bus.bready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'({bus.arready, bus.awready, bus.wready}), 32'd0);
    check("rst_valid", 32'({bus.rvalid, bus.bvalid}), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    s_areset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);

    // Aligned full write then read back.
    axi_write(Base + 32'h08, 32'hA5A5_1234, 4'hF, 0, 0, 0);
    axi_read(Base + 32'h08, 0, rd);
    check("full_rd_const", rd, 32'hA5A5_1234);

    // Data three cycles ahead of address, partial strobe over a zero word.
    axi_write(Base + 32'h0C, 32'h1122_3344, 4'b0101, 3, 0, 0);
    axi_read(Base + 32'h0C, 0, rd);
    check("partial_const", rd, 32'h0022_0044);

    // Out-of-range write must not alias onto word 0.
    axi_write(Base + 32'h00, 32'hCAFE_F00D, 4'hF, 1, 2, 0);
    axi_write(Base + 32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(Base + 32'h40, 0, rd);
    axi_read(Base + 32'h00, 0, rd);
    check("oor_no_alias", rd, 32'hCAFE_F00D);

    // Backpressure on both response channels.
    axi_write(Base + 32'h10, 32'h5555_AAAA, 4'hF, 0, 0, 5);
    axi_read(Base + 32'h10, 5, rd);

    // Read handshake on the same edge as a write commit to the same word.
    @(posedge clk); #1;
    bus.araddr = Base + 32'h10; bus.arvalid = 1'b1;
    bus.awaddr = Base + 32'h10; bus.awvalid = 1'b1;
    bus.wdata = 32'h0BAD_CAFE;  bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    check("same_edge_rdy", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);
    model_read(Base + 32'h10, old_d, old_r);
    void'(model_write(Base + 32'h10, 32'h0BAD_CAFE, 4'hF));
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    r_lat = 0; b_lat = 0; r_seen = '0; b_seen = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rvalid && r_lat == 0) begin r_lat = i; r_seen = bus.rdata; end
      if (bus.bvalid && b_lat == 0) begin b_lat = i; b_seen = bus.bresp; end
    end
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("same_edge_rlat", 32'(r_lat), 32'(ExpLat));
    check("same_edge_old", r_seen, old_d);
    check("same_edge_blat", 32'(b_lat), 32'd1);
    check("same_edge_bresp", 32'(b_seen), 32'd0);
    axi_read(Base + 32'h10, 0, rd);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(rand_addr(), $urandom_range(0, 3), rd);
    end

    // Reset with a read in its response phase and a write holding only its address.
    axi_write(Base + 32'h14, 32'h1234_5678, 4'hF, 0, 0, 0);
    @(posedge clk); #1;
    bus.araddr = Base + 32'h14; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    r_lat = 0;
    for (int i = 1; i <= 40 && r_lat == 0; i++) begin
      @(negedge clk);
      if (bus.rvalid) r_lat = i;
    end
    check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
    @(posedge clk); #1;
    bus.awaddr = Base + 32'h18; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_aheld", 32'({bus.awready, bus.wready}), 32'd1);
    @(posedge clk); #1;
    s_areset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'({bus.rvalid, bus.bvalid}), 32'd0);
    check("rst_mid_ready", 32'({bus.arready, bus.awready, bus.wready}), 32'd0);
    check("rst_mid_rdata", bus.rdata, 32'h0);
    check("rst_mid_resp", 32'({bus.rresp, bus.bresp}), 32'd0);
    @(posedge clk); #1;
    s_areset = 1'b0;
    model_clear();
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rvalid || bus.bvalid) stray++;
    end
    check("rst_no_resp", 32'(stray), 32'd0);
    axi_read(Base + 32'h14, 0, rd);
    check("rst_cleared", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
